// File: rtl/byte_pingpong_feeder.sv
// Two-bank ping-pong byte buffer feeding byte_selector.
// Bytes land in banks 0,1,0,1,... and are consumed in the same order.
// select always points at the oldest unconsumed bank.
module byte_pingpong_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_buf0,
    output logic [WIDTH-1:0] o_buf1,
    output logic             o_select,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_xfer_count
);

    logic [WIDTH-1:0] r_bank0;
    logic [WIDTH-1:0] r_bank1;
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_full;
    logic [CNT_W-1:0] r_xfer_count;

    logic             w_wr;
    logic             w_rd;
    logic [1:0]       w_full_next;

    // Handshake qualifiers and status outputs, decoded from registered state only
    // so there is no combinational path between the two handshakes.
    always_comb begin
        o_in_ready  = !i_rst && !r_full[r_wp];
        o_out_valid = r_full[r_rp];
        o_occupancy = {1'b0, r_full[0]} + {1'b0, r_full[1]};
        w_wr        = i_in_valid && o_in_ready;
        w_rd        = o_out_valid && i_out_ready;
    end

    // Next full flags. When wp == rp only one of write/read can be legal,
    // so the two updates never touch the same bit in one cycle.
    always_comb begin
        w_full_next = r_full;
        if (w_wr) w_full_next[r_wp] = 1'b1;
        if (w_rd) w_full_next[r_rp] = 1'b0;
    end

    // Bank storage, pointers, full flags and consumed-byte counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank0      <= '0;
            r_bank1      <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_full       <= 2'b00;
            r_xfer_count <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_wr) begin
                if (r_wp) r_bank1 <= i_in_data;
                else      r_bank0 <= i_in_data;
                r_wp <= ~r_wp;
            end
            if (w_rd) begin
                r_rp         <= ~r_rp;
                r_xfer_count <= r_xfer_count + 1'b1;
            end
        end
    end

    assign o_buf0       = r_bank0;
    assign o_buf1       = r_bank1;
    assign o_select     = r_rp;
    assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_byte_pingpong_feeder.sv
// Self-checking bench for byte_pingpong_feeder. A second instance built with
// a 4-bit counter shares all inputs and is used to observe counter wrap.
module tb_byte_pingpong_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  buf0;
    logic [7:0]  buf1;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occ;
    logic [15:0] cnt;

    logic        in_ready4;
    logic [7:0]  buf0_4;
    logic [7:0]  buf1_4;
    logic        sel4;
    logic        out_valid4;
    logic [1:0]  occ4;
    logic [3:0]  cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: FIFO of stored bytes plus written/consumed totals
    logic [7:0] m_q[$];
    logic [7:0] m_bank[2];
    int         m_nin;
    int         m_nout;

    always #5 clk = ~clk;

    byte_pingpong_feeder #(.WIDTH(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_buf0(buf0), .o_buf1(buf1), .o_select(sel),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_occupancy(occ),
        .o_xfer_count(cnt)
    );

    byte_pingpong_feeder #(.WIDTH(8), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(in_ready4), .o_buf0(buf0_4), .o_buf1(buf1_4), .o_select(sel4),
        .o_out_valid(out_valid4), .i_out_ready(out_ready), .o_occupancy(occ4),
        .o_xfer_count(cnt4)
    );

    function automatic logic [7:0] presented();
        return sel ? buf1 : buf0;
    endfunction

    // Advance one clock; update the model from the handshake rules.
    task automatic tick();
        bit wr;
        bit rd;
        wr = in_valid && !rst && (m_q.size() < 2);
        rd = !rst && (m_q.size() > 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_bank[0] = 8'h00;
            m_bank[1] = 8'h00;
            m_nin  = 0;
            m_nout = 0;
        end else begin
            if (rd) begin
                void'(m_q.pop_front());
                m_nout++;
            end
            if (wr) begin
                m_q.push_back(in_data);
                m_bank[m_nin % 2] = in_data;
                m_nin++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready_during_rst got %0b want 0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (buf0 !== 8'h00 || buf1 !== 8'h00) begin
            n_err++; $display("FAIL reset_bufs got %h/%h want 00/00", buf0, buf1);
        end
        n_cmp++;
        if (sel !== 1'b0 || out_valid !== 1'b0 || occ !== 2'd0) begin
            n_err++; $display("FAIL reset_status got sel=%0b ov=%0b occ=%0d want 0/0/0", sel, out_valid, occ);
        end
        n_cmp++;
        if (cnt !== 16'd0 || cnt4 !== 4'd0) begin
            n_err++; $display("FAIL reset_count got %0d/%0d want 0/0", cnt, cnt4);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready_after got %0b want 1", in_ready);
        end
    endtask

    task automatic test_fill();
        logic [7:0] seq[2];
        seq[0] = 8'h01; seq[1] = 8'h10;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = seq[i];
            tick();
        end
        n_cmp++;
        if (buf0 !== 8'h01 || buf1 !== 8'h10) begin
            n_err++; $display("FAIL fill_bufs got %h/%h want 01/10", buf0, buf1);
        end
        n_cmp++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || sel !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL fill_status got occ=%0d ir=%0b sel=%0b ov=%0b want 2/0/0/1",
                              occ, in_ready, sel, out_valid);
        end
        in_data = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (buf0 !== 8'h01 || buf1 !== 8'h10 || occ !== 2'd2 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL full_hold cyc %0d got %h/%h occ=%0d ir=%0b want 01/10 2 0",
                                  i, buf0, buf1, occ, in_ready);
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp_b[2];
        exp_b[0] = 8'h01; exp_b[1] = 8'h10;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || presented() !== exp_b[i] || sel !== i[0]) begin
                n_err++; $display("FAIL drain_byte %0d got ov=%0b byte=%h sel=%0b want 1 %h %0b",
                                  i, out_valid, presented(), sel, exp_b[i], i[0]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || sel !== 1'b0 || cnt !== 16'd2) begin
            n_err++; $display("FAIL drain_end got ov=%0b sel=%0b cnt=%0d want 0 0 2", out_valid, sel, cnt);
        end
    endtask

    task automatic test_stream();
        logic [7:0] seq[5];
        int k_in;
        int k_out;
        seq[0] = 8'h20; seq[1] = 8'h02; seq[2] = 8'hFF; seq[3] = 8'hAA; seq[4] = 8'h80;
        k_in = 0; k_out = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 8 && k_out < 5; c++) begin
            in_valid = (k_in < 5);
            in_data  = (k_in < 5) ? seq[k_in] : 8'h00;
            #1;
            if (c >= 1 && c <= 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || presented() !== seq[k_out] || sel !== k_out[0]
                    || (c <= 4 && occ !== 2'd1)) begin
                    n_err++; $display("FAIL stream_cyc %0d got ov=%0b byte=%h sel=%0b occ=%0d want 1 %h %0b",
                                      c, out_valid, presented(), sel, occ, seq[k_out], k_out[0]);
                end
            end
            if (in_valid && in_ready) k_in++;
            if (out_valid) k_out++;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (k_out !== 5 || cnt !== 16'd7 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_total got consumed=%0d cnt=%0d ov=%0b want 5 7 0", k_out, cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        logic       s;
        b = 8'($urandom);
        out_ready = 1'b0; in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
        s = m_nout[0];
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            tick();
            n_cmp++;
            if (sel !== s || presented() !== b || out_valid !== 1'b1 || occ !== 2'd1) begin
                n_err++; $display("FAIL hold_cyc %0d got sel=%0b byte=%h ov=%0b occ=%0d want %0b %h 1 1",
                                  i, sel, presented(), out_valid, occ, s, b);
            end
        end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hC3;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (buf0 !== 8'h00 || buf1 !== 8'h00 || sel !== 1'b0 || out_valid !== 1'b0
            || occ !== 2'd0 || cnt !== 16'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst got b0=%h b1=%h sel=%0b ov=%0b occ=%0d cnt=%0d ir=%0b want 00 00 0 0 0 0 1",
                              buf0, buf1, sel, out_valid, occ, cnt, in_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== (m_q.size() < 2) || out_valid !== (m_q.size() > 0)
                || occ !== 2'(m_q.size()) || sel !== m_nout[0]
                || buf0 !== m_bank[0] || buf1 !== m_bank[1] || cnt !== m_nout[15:0]
                || (m_q.size() > 0 && presented() !== m_q[0])) begin
                n_err++; $display("FAIL random_cyc %0d got ir=%0b ov=%0b occ=%0d sel=%0b b0=%h b1=%h cnt=%0d want ir=%0b ov=%0b occ=%0d sel=%0b b0=%h b1=%h cnt=%0d",
                                  c, in_ready, out_valid, occ, sel, buf0, buf1, cnt,
                                  (m_q.size() < 2), (m_q.size() > 0), m_q.size(), m_nout[0],
                                  m_bank[0], m_bank[1], m_nout[15:0]);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && m_nout < 17; c++) begin
            in_data = 8'($urandom);
            tick();
            if (m_nout == 15) begin
                n_cmp++;
                if (cnt4 !== 4'hF) begin
                    n_err++; $display("FAIL wrap_15 got %h want f", cnt4);
                end
            end else if (m_nout == 16) begin
                n_cmp++;
                if (cnt4 !== 4'h0 || cnt !== 16'd16) begin
                    n_err++; $display("FAIL wrap_16 got %h/%0d want 0/16", cnt4, cnt);
                end
            end else if (m_nout == 17) begin
                n_cmp++;
                if (cnt4 !== 4'h1) begin
                    n_err++; $display("FAIL wrap_17 got %h want 1", cnt4);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (m_nout != 17 || cnt !== 16'd17) begin
            n_err++; $display("FAIL wrap_budget got consumed=%0d cnt=%0d want 17 17", m_nout, cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        m_nin = 0; m_nout = 0; m_bank[0] = 8'h00; m_bank[1] = 8'h00;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_backpressure();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
